rfm_act_issuer: RTL



---
 rtl/rfm_act_issuer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rfm_act_issuer.sv
// rtl/rfm_act_issuer.sv - ACT/RFM initiator with tRC/tRFM spacing, RAA counting and NRR victim refresh
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_addr       activation request in; req_ready (combinational) accepts it
//   act_cmd/act_addr         one-cycle ACT pulse and its row (row held until the next ACT)
//   rfm_cmd                  one-cycle RFM pulse, issued when raa_cnt reaches RFM_TH
//   nrr_cmd/nrr_addr         aggressor-row report from the bank tracker
//   vref_valid/vref_addr     victim-row refresh request, held until vref_ready
//   raa_cnt                  rolling accumulated-ACT count
//   nrr_ovf                  sticky: an NRR report was dropped on a full queue
//
// Build option: RFM_NRR_EN builds the NRR queue, the victim generator and nrr_ovf.
// Without it the NRR inputs are ignored and vref_valid/vref_addr/nrr_ovf are tied to 0.
module rfm_act_issuer #(
    parameter int ADDR_SIZE  = 18,
    parameter int RFM_TH     = 20,
    parameter int T_RC       = 60,
    parameter int T_RFM      = 200,
    parameter int NRR_QDEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [ADDR_SIZE-1:0]           req_addr,
    output logic                           req_ready,
    output logic                           act_cmd,
    output logic [ADDR_SIZE-1:0]           act_addr,
    output logic                           rfm_cmd,
    input  logic                           nrr_cmd,
    input  logic [ADDR_SIZE-1:0]           nrr_addr,
    output logic                           vref_valid,
    output logic [ADDR_SIZE-1:0]           vref_addr,
    input  logic                           vref_ready,
    output logic [$clog2(RFM_TH+1)-1:0]    raa_cnt,
    output logic                           nrr_ovf
);

    localparam int RW    = $clog2(RFM_TH + 1);
    localparam int T_MAX = (T_RC > T_RFM) ? T_RC : T_RFM;
    localparam int TW    = $clog2(T_MAX);

    localparam logic [RW-1:0] RAA_MAX  = RW'(RFM_TH);
    // Timer loads are "minus 3": one cycle in ACT/RFM, one cycle in which the
    // timer reads 0, one cycle back in IDLE before the next pulse can be launched.
    localparam logic [TW-1:0] RC_LOAD  = TW'(T_RC - 3);
    localparam logic [TW-1:0] RFM_LOAD = TW'(T_RFM - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_GAP,
        S_RFM,
        S_RFM_WAIT
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;

    // A full RAA window blocks new requests so the pending RFM goes first.
    assign req_ready = (state == S_IDLE) && (raa_cnt < RAA_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            act_cmd  <= 1'b0;
            act_addr <= '0;
            rfm_cmd  <= 1'b0;
            raa_cnt  <= '0;
        end else begin
            act_cmd <= 1'b0;
            rfm_cmd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (raa_cnt == RAA_MAX) begin
                        rfm_cmd <= 1'b1;
                        state   <= S_RFM;
                    end else if (req_valid && req_ready) begin
                        act_addr <= req_addr;
                        act_cmd  <= 1'b1;
                        state    <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (raa_cnt != RAA_MAX) begin
                        raa_cnt <= raa_cnt + 1'b1;
                    end
                    timer <= RC_LOAD;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_RFM: begin
                    raa_cnt <= '0;
                    timer   <= RFM_LOAD;
                    state   <= S_RFM_WAIT;
                end
                S_RFM_WAIT: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RFM_NRR_EN
    localparam int PW = $clog2(NRR_QDEPTH);
    localparam int CW = $clog2(NRR_QDEPTH + 1);
    localparam logic [CW-1:0]        Q_FULL    = CW'(NRR_QDEPTH);
    localparam logic [CW-1:0]        Q_ONE     = CW'(1);
    localparam logic [ADDR_SIZE-1:0] ADDR_ONES = '1;

    logic [ADDR_SIZE-1:0] q_mem [NRR_QDEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_next;
    logic [CW-1:0]        q_cnt;
    logic [ADDR_SIZE-1:0] q_head;
    logic [ADDR_SIZE-1:0] q_second;
    logic                 vref_last;
    logic                 pop;
    logic                 push;

    // First victim of an aggressor row: row-1 unless the row is 0. The upper
    // bit says whether that victim is also the last one for the entry.
    function automatic logic [ADDR_SIZE:0] first_victim(input logic [ADDR_SIZE-1:0] a);
        if (a != '0) begin
            return {(a == ADDR_ONES), a - 1'b1};
        end
        return {1'b1, a + 1'b1};
    endfunction

    assign rd_next  = rd_ptr + 1'b1;
    assign q_head   = q_mem[rd_ptr];
    assign q_second = q_mem[rd_next];
    // The head entry is only released once its final victim is taken.
    assign pop      = vref_valid && vref_ready && vref_last;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push     = nrr_cmd && ((q_cnt != Q_FULL) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= nrr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q_cnt      <= '0;
            vref_valid <= 1'b0;
            vref_addr  <= '0;
            vref_last  <= 1'b0;
            nrr_ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
            if (nrr_cmd && !push) begin
                nrr_ovf <= 1'b1;
            end

            if (vref_valid) begin
                if (vref_ready) begin
                    if (!vref_last) begin
                        vref_addr <= q_head + 1'b1;
                        vref_last <= 1'b1;
                    end else if (q_cnt > Q_ONE) begin
                        // Chain straight into the next entry to keep one victim per cycle.
                        {vref_last, vref_addr} <= first_victim(q_second);
                    end else begin
                        vref_valid <= 1'b0;
                    end
                end
            end else if (q_cnt != '0) begin
                {vref_last, vref_addr} <= first_victim(q_head);
                vref_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_nrr;
    assign unused_nrr = ^{nrr_cmd, nrr_addr, vref_ready};
    assign vref_valid = 1'b0;
    assign vref_addr  = '0;
    assign nrr_ovf    = 1'b0;
`endif

endmodule
